// File: rtl/io_map_pkg.sv
// Shared definitions for the CPU-to-peripheral I/O bridge: register offsets,
// FSM states, decode results and the address decode helper.
package io_map_pkg;

    localparam logic [3:0] LEDR_OFS = 4'h0;
    localparam logic [3:0] HEX_OFS  = 4'h4;
    localparam logic [3:0] SW_OFS   = 4'h8;
    localparam logic [3:0] KEY_OFS  = 4'hC;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef enum logic [2:0] {DEC_LEDR, DEC_HEX, DEC_SW, DEC_KEY, DEC_ERR} dec_e;

    // Map a window hit, byte offset and direction onto a target. Misaligned
    // offsets fall through to DEC_ERR, as do writes to inputs and HEX reads.
    function automatic dec_e decode(input logic in_win, input logic [3:0] ofs,
                                    input logic we);
        dec_e d;
        d = DEC_ERR;
        if (in_win) begin
            case (ofs)
                LEDR_OFS: d = DEC_LEDR;
                HEX_OFS:  d = we ? DEC_HEX : DEC_ERR;
                SW_OFS:   d = we ? DEC_ERR : DEC_SW;
                KEY_OFS:  d = we ? DEC_ERR : DEC_KEY;
                default:  d = DEC_ERR;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/io_bus_bridge_sync_ff.sv
// Multi-flop synchronizer for asynchronous board inputs (switches, keys).
module sync_ff #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    // Shift the raw input through STAGES flops; stage 0 is the metastable one.
    always_ff @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/io_bus_bridge.sv
// Memory-mapped I/O bridge: one CPU request at a time, IDLE -> ACCESS -> RESP.
// Stores produce a one-cycle strobe in ACCESS; loads and errors are registered
// in ACCESS and presented with the ack in RESP.
import io_map_pkg::*;

module io_bus_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'hFF20_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        ledr_write,
    output logic        hex_write,
    output logic [31:0] io_writedata,
    input  logic [9:0]  ledr_state,
    input  logic [9:0]  sw_in,
    input  logic [3:0]  key_in
);

    state_e      state, state_nxt;
    logic        lat_we;
    logic [31:0] lat_addr;
    dec_e        dec;
    logic [31:0] rd_sel;
    logic [9:0]  sw_sync;
    logic [3:0]  key_sync;

    sync_ff #(.WIDTH(10), .STAGES(SYNC_STAGES)) u_sw_sync (
        .clk(clk), .rst_n(rst_n), .d(sw_in), .q(sw_sync)
    );

    sync_ff #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_key_sync (
        .clk(clk), .rst_n(rst_n), .d(key_in), .q(key_sync)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: ACCESS and RESP are fixed single cycles, req ignored there.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request when it is accepted; io_writedata holds until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            io_writedata <= '0;
        end else if (state == IDLE && cpu_req) begin
            lat_we       <= cpu_we;
            lat_addr     <= cpu_addr;
            io_writedata <= cpu_wdata;
        end
    end

    assign dec = decode(lat_addr[31:4] == BASE_ADDR[31:4], lat_addr[3:0], lat_we);

    // Load data select; stores and errors return zero.
    always_comb begin
        rd_sel = '0;
        if (!lat_we) begin
            case (dec)
                DEC_LEDR: rd_sel = {22'b0, ledr_state};
                DEC_SW:   rd_sel = {22'b0, sw_sync};
                DEC_KEY:  rd_sel = {28'b0, ~key_sync};
                default:  rd_sel = '0;
            endcase
        end
    end

    // Response registers: loaded in ACCESS, so they are live only during RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ack   <= (state == ACCESS);
            cpu_rdata <= (state == ACCESS) ? rd_sel : '0;
            cpu_err   <= (state == ACCESS) && (dec == DEC_ERR);
        end
    end

    // Strobes are gated by rst_n so a reset landing in ACCESS suppresses the write.
    assign ledr_write = rst_n && (state == ACCESS) && lat_we && (dec == DEC_LEDR);
    assign hex_write  = rst_n && (state == ACCESS) && lat_we && (dec == DEC_HEX);

endmodule

// File: tb/tb_io_bus_bridge.sv
// Bench for io_bus_bridge: reset check, directed vector table, back-to-back and
// mid-transaction reset sequences, then random traffic against a reference model.
module tb_io_bus_bridge;

    localparam logic [31:0] BASE = 32'hFF20_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ack, cpu_err;
    logic [31:0] cpu_rdata;
    logic        ledr_write, hex_write;
    logic [31:0] io_writedata;
    logic [9:0]  ledr_state;
    logic [9:0]  sw_in;
    logic [3:0]  key_in;
    logic [9:0]  ledr_reg = '0;

    int n_pass = 0;
    int n_total = 0;

    io_bus_bridge #(.BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ledr_write(ledr_write), .hex_write(hex_write), .io_writedata(io_writedata),
        .ledr_state(ledr_state), .sw_in(sw_in), .key_in(key_in)
    );

    always #5 clk = ~clk;

    // Board LEDR register: captures on the strobe edge.
    always_ff @(posedge clk) if (ledr_write) ledr_reg <= io_writedata[9:0];
    assign ledr_state = ledr_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One transaction: req raised at a negedge, observed for 6 cycles.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nl, output int nh, output logic [31:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = -1; nl = 0; nh = 0; rd = '0; er = 1'b0; wd = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (ledr_write) begin nl++; wd = io_writedata; end
            if (hex_write)  begin nh++; wd = io_writedata; end
            if (cpu_ack) begin
                if (lat < 0) begin lat = c; rd = cpu_rdata; er = cpu_err; end
                else lat = 99;
                cpu_req = 1'b0;
            end
        end
    endtask

    // Reference: decode from the address map rules using plain arithmetic.
    function automatic void ref_model(input logic we, input logic [31:0] addr,
                                      input logic [9:0] sw, input logic [3:0] key,
                                      input logic [9:0] led, output logic [31:0] rd,
                                      output logic er, output int nl, output int nh);
        longint off;
        logic bad;
        off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
        bad = (off < 0) || (off > 15) || (addr % 4 != 0) || (we && off >= 8) || (!we && off == 4);
        er = bad;
        rd = '0;
        nl = (!bad && we && off == 0) ? 1 : 0;
        nh = (!bad && we && off == 4) ? 1 : 0;
        if (!bad && !we) begin
            if (off == 0)       rd = 32'(led);
            else if (off == 8)  rd = 32'(sw);
            else if (off == 12) rd = 32'(4'hF - key);
        end
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  sw;
        logic [3:0]  key;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_nl;
        int          exp_nh;
    } vec_t;

    initial begin
        vec_t        vt[12];
        logic [31:0] rd, wd, e_rd;
        logic        er, e_er;
        int          lat, nl, nh, e_nl, e_nh;
        logic [9:0]  m_led;
        int          stb_cyc[$];
        int          ack_cyc[$];
        logic        rst_bad;

        vt[0]  = '{1'b1, 32'hFF20_0000, 32'h0000_02A5, 10'h000, 4'hF, 32'h0, 1'b0, 1, 0};
        vt[1]  = '{1'b1, 32'hFF20_0000, 32'h0000_0155, 10'h000, 4'hF, 32'h0, 1'b0, 1, 0};
        vt[2]  = '{1'b0, 32'hFF20_0000, 32'h0,         10'h000, 4'hF, 32'h155, 1'b0, 0, 0};
        vt[3]  = '{1'b0, 32'hFF20_0008, 32'h0,         10'h3C3, 4'hF, 32'h3C3, 1'b0, 0, 0};
        vt[4]  = '{1'b0, 32'hFF20_000C, 32'h0,         10'h3C3, 4'hA, 32'h5,   1'b0, 0, 0};
        vt[5]  = '{1'b1, 32'hFF20_0008, 32'hDEAD_BEEF, 10'h000, 4'hF, 32'h0, 1'b1, 0, 0};
        vt[6]  = '{1'b0, 32'hFF20_0002, 32'h0,         10'h3FF, 4'hF, 32'h0, 1'b1, 0, 0};
        vt[7]  = '{1'b0, 32'hFF20_0010, 32'h0,         10'h3FF, 4'hF, 32'h0, 1'b1, 0, 0};
        vt[8]  = '{1'b0, 32'hFF20_0004, 32'h0,         10'h3FF, 4'hF, 32'h0, 1'b1, 0, 0};
        vt[9]  = '{1'b1, 32'hFF20_0004, 32'h1234_5678, 10'h000, 4'hF, 32'h0, 1'b0, 0, 1};
        vt[10] = '{1'b0, 32'hFF1F_FFFC, 32'h0,         10'h3FF, 4'hF, 32'h0, 1'b1, 0, 0};
        vt[11] = '{1'b1, 32'hFF20_000C, 32'h0000_0001, 10'h000, 4'hF, 32'h0, 1'b1, 0, 0};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        sw_in = '0; key_in = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_ack",   32'(cpu_ack), 32'h0);
        chk("reset_rdata", cpu_rdata, 32'h0);
        chk("reset_err",   32'(cpu_err), 32'h0);
        chk("reset_strobes", 32'({ledr_write, hex_write}), 32'h0);
        chk("reset_wdata", io_writedata, 32'h0);
        rst_n = 1'b1;

        // Directed vectors.
        foreach (vt[i]) begin
            sw_in = vt[i].sw; key_in = vt[i].key;
            repeat (3) @(negedge clk);
            run_txn(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat, nl, nh, wd);
            chk($sformatf("vec%0d_lat", i),   32'(lat), 32'd2);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i),   32'(er), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_ledr_n", i), 32'(nl), 32'(vt[i].exp_nl));
            chk($sformatf("vec%0d_hex_n", i),  32'(nh), 32'(vt[i].exp_nh));
            if (vt[i].exp_nl + vt[i].exp_nh > 0)
                chk($sformatf("vec%0d_wdata", i), wd, vt[i].wdata);
        end

        // Back-to-back: req held through the first ack.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = BASE; cpu_wdata = 32'h0000_0033;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ledr_write || hex_write) stb_cyc.push_back(c);
            if (cpu_ack) begin
                ack_cyc.push_back(c);
                if (ack_cyc.size() == 2) cpu_req = 1'b0;
            end
        end
        chk("b2b_strobe_count", 32'(stb_cyc.size()), 32'd2);
        chk("b2b_ack_count",    32'(ack_cyc.size()), 32'd2);
        if (stb_cyc.size() == 2) chk("b2b_strobe_spacing", 32'(stb_cyc[1] - stb_cyc[0]), 32'd3);
        if (ack_cyc.size() >= 1) chk("b2b_first_ack", 32'(ack_cyc[0]), 32'd2);

        // Reset during ACCESS of a HEX store.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = BASE + 32'h4; cpu_wdata = 32'hCAFE_0001;
        @(negedge clk);
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("rst_mid_hex_write", 32'(hex_write), 32'h0);
        rst_bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_ack || hex_write || ledr_write) rst_bad = 1'b1;
        end
        chk("rst_mid_no_ack_no_strobe", 32'(rst_bad), 32'h0);
        rst_n = 1'b1;
        sw_in = 10'h2AA; key_in = 4'hE;
        repeat (3) @(negedge clk);
        run_txn(1'b0, BASE + 32'hC, 32'h0, rd, er, lat, nl, nh, wd);
        chk("post_rst_lat",   32'(lat), 32'd2);
        chk("post_rst_rdata", rd, 32'h1);
        run_txn(1'b1, BASE + 32'h4, 32'h0000_00AB, rd, er, lat, nl, nh, wd);
        chk("post_rst_hex_n", 32'(nh), 32'd1);
        chk("post_rst_hex_wdata", wd, 32'h0000_00AB);

        // Random traffic against the reference model.
        m_led = ledr_reg;
        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [31:0] addr, wdata;
            int          r;
            we = 1'($urandom_range(0, 1));
            wdata = $urandom;
            r = $urandom_range(0, 9);
            if (r <= 5)      addr = BASE + 32'(4 * $urandom_range(0, 3));
            else if (r == 6) addr = BASE + 32'($urandom_range(0, 15));
            else if (r == 7) addr = BASE + 32'h10 + 32'($urandom_range(0, 64));
            else if (r == 8) addr = BASE - 32'(4 * $urandom_range(1, 4));
            else             addr = $urandom;
            sw_in = 10'($urandom); key_in = 4'($urandom);
            repeat (3) @(negedge clk);
            ref_model(we, addr, sw_in, key_in, m_led, e_rd, e_er, e_nl, e_nh);
            run_txn(we, addr, wdata, rd, er, lat, nl, nh, wd);
            if (e_nl == 1) m_led = wdata[9:0];
            chk($sformatf("rnd%0d_lat", t),    32'(lat), 32'd2);
            chk($sformatf("rnd%0d_rdata", t),  rd, e_rd);
            chk($sformatf("rnd%0d_err", t),    32'(er), 32'(e_er));
            chk($sformatf("rnd%0d_ledr_n", t), 32'(nl), 32'(e_nl));
            chk($sformatf("rnd%0d_hex_n", t),  32'(nh), 32'(e_nh));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
